ddr_arbiter: RTL and testbench
==============================

Name: ddr_arbiter

Overview:
- Shares the single DDR controller command port between the VGA scan-out fetch (video, read-only) and the drawing engine (draw, read/write).
- Schedules periodic auto-refresh requests.
- Only one transaction is in flight at a time. Completions and read data are routed back to the requester that owns the transaction.
- Sits between the pixel/draw logic and the DDR controller, in the clk133_p domain.

Parameters:
REFRESH_INTERVAL, 1000, clk133_p cycles between refresh requests (at most 7.8 us).
STARVE_LIMIT, 8, consecutive video grants allowed while draw waits before draw is forced.

Ports:
clk133_p  in  1  system clock, rising-edge
rst_n  in  1  asynchronous active-low reset
vidReq  in  1  video read request; held until vidGrant
vidAddress  in  24  video word address {BA[1:0], row[12:0], col[8:0]}
vidGrant  out  1  one-cycle pulse: video request accepted
vidDataValid  out  1  one-cycle pulse: vidData valid
vidData  out  16  video read data
drwReq  in  1  draw request; held until drwGrant
drwWrite  in  1  1 = write, 0 = read
drwAddress  in  24  draw word address
drwWriteData  in  16  draw write data
drwGrant  out  1  one-cycle pulse: draw request accepted
drwDone  out  1  one-cycle pulse: draw transaction complete
drwReadData  out  16  draw read data, valid with drwDone on reads
ctlInitDone  in  1  DDR initialisation complete
ctlCmdValid  out  1  command valid to controller
ctlCmdReady  in  1  controller accepts command
ctlCmdType  out  2  00 read, 01 write, 10 refresh
ctlAddress  out  24  command address
ctlWriteData  out  16  write data
ctlDone  in  1  one-cycle pulse: current command finished
ctlReadData  in  16  read data, valid with ctlDone
refreshOverrun  out  1  sticky: refresh deadline missed

Behaviour:
- Reset (rst_n low, async):
  - State goes to IDLE. All outputs are 0.
  - Refresh counter, starveCount, refreshPending, owner and captured fields are cleared.
- States:
  - IDLE: grants are made only here, and only when ctlInitDone=1.
  - ISSUE: ctlCmdValid=1 with registered type/address/data held stable.
  - On a rising edge with ctlCmdReady=1, ISSUE goes to WAIT.
  - WAIT: on ctlDone=1, returns to IDLE.
  - ctlDone in IDLE or ISSUE is ignored.
- Arbitration priority in IDLE:
  1. refreshPending.
  2. drwReq when starveCount==STARVE_LIMIT.
  3. vidReq.
  4. drwReq.
- Grant cycle (the edge IDLE goes to ISSUE):
  - Winner's address, write flag and data are captured.
  - The matching grant is pulsed for one cycle. Refresh has no grant output.
  - Owner is recorded: VID, DRW or REF.
  - Requesters drop or refresh their req after seeing the grant.
  - Because of the registered grant, a req still high in the cycle after the grant is not double-counted: IDLE is not re-entered until completion.
- Completion, one cycle after ctlDone (registered):
  - Owner VID: vidDataValid=1 with vidData=ctlReadData.
  - Owner DRW: drwDone=1, plus drwReadData=ctlReadData on reads; drwReadData holds its last value on writes.
  - Owner REF: no output.
- Latency: grant at cycle N, ctlCmdValid from N+1. With ready at N+1 and ctlDone at M, data/done pulse at M+1. Next grant is possible at M+1 (back-to-back).
- Refresh timer:
  - Counts 0..REFRESH_INTERVAL-1 while ctlInitDone=1, wrapping to 0. It is frozen at its value while ctlInitDone=0.
  - On wrap, sets refreshPending.
  - refreshPending clears on refresh grant.
  - Wrap in the same cycle as a refresh grant leaves pending set for the new interval, with no overrun.
  - Wrap while pending is already set (and not being granted) sets refreshOverrun; it stays set until reset.
- Starvation:
  - On a video grant with drwReq=1, starveCount increments, saturating at STARVE_LIMIT.
  - On a video grant with drwReq=0, or on a draw grant, starveCount goes to 0.
  - A refresh grant does not change starveCount.
- ctlInitDone falling mid-transaction: the current transaction completes normally. No new grants until it rises.
- Simultaneous vidReq and drwReq with starveCount<limit: video wins.

Test Plan:
- Reset, then ctlInitDone=1. vidReq with vidAddress=24'h123456. Controller ready immediately, ctlDone 4 cycles later with ctlReadData=16'h7654 -> vidGrant at cycle 1. ctlCmdType=00, ctlAddress=24'h123456. vidDataValid with vidData=16'h7654 one cycle after ctlDone.
- drwReq write, drwAddress=0, drwWriteData=16'hA5A5. ctlCmdReady delayed 3 cycles -> ctlCmdValid held 3 cycles with stable fields. drwDone one cycle after ctlDone.
- vidReq and drwReq both continuously high, immediate done -> 8 video grants, then 1 draw grant, repeating. starveCount returns to 0 after the draw grant.
- REFRESH_INTERVAL=16, no traffic -> ctlCmdType=10 issued every 16 cycles. refreshOverrun stays 0.
- REFRESH_INTERVAL=16, ctlDone withheld for 40 cycles on a video read -> refreshOverrun=1 after the second wrap. It stays 1 after the transaction finishes; refresh is granted first after that.
- rst_n low mid-WAIT -> all outputs 0 asynchronously. ctlCmdValid=0. No stale vidDataValid after release.

Source files
------------

// File: rtl/ddr_arbiter.sv
// Arbiter sharing the single DDR controller command port between video scan-out
// reads, drawing-engine reads/writes and periodic auto-refresh; one command in flight.
module ddr_arbiter #(
    parameter int REFRESH_INTERVAL = 1000,
    parameter int STARVE_LIMIT     = 8
) (
    input  logic        clk133_p,
    input  logic        rst_n,
    input  logic        vidReq,
    input  logic [23:0] vidAddress,
    output logic        vidGrant,
    output logic        vidDataValid,
    output logic [15:0] vidData,
    input  logic        drwReq,
    input  logic        drwWrite,
    input  logic [23:0] drwAddress,
    input  logic [15:0] drwWriteData,
    output logic        drwGrant,
    output logic        drwDone,
    output logic [15:0] drwReadData,
    input  logic        ctlInitDone,
    output logic        ctlCmdValid,
    input  logic        ctlCmdReady,
    output logic [1:0]  ctlCmdType,
    output logic [23:0] ctlAddress,
    output logic [15:0] ctlWriteData,
    input  logic        ctlDone,
    input  logic [15:0] ctlReadData,
    output logic        refreshOverrun
);

    localparam int RW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_INTERVAL - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    localparam logic [1:0] CMD_RD  = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_REF = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_DRW, OWN_REF} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q;
    logic [1:0]    cmdType_q;
    logic [23:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [RW-1:0] refCnt_q, refCnt_d;
    logic          refPend_q, refPend_d;
    logic          overrun_q, overrun_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          vidGrant_q, drwGrant_q;
    logic          vidValid_q, drwDone_q;
    logic [15:0]   vidData_q, drwRdData_q;

    logic can_grant, gnt_ref, gnt_drw, gnt_vid, any_gnt;
    logic drw_forced, wrap, done_evt;

    // Priority: refresh, starved draw, video, draw
    always_comb begin
        can_grant  = (state_q == IDLE) && ctlInitDone;
        drw_forced = drwReq && (starve_q == STARVE_MAX);
        gnt_ref    = can_grant && refPend_q;
        gnt_drw    = can_grant && !refPend_q && drwReq && (drw_forced || !vidReq);
        gnt_vid    = can_grant && !refPend_q && vidReq && !drw_forced;
        any_gnt    = gnt_ref || gnt_drw || gnt_vid;
        done_evt   = (state_q == WAIT) && ctlDone;
    end

    always_ff @(posedge clk133_p or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_gnt)     state_d = ISSUE;
            ISSUE:   if (ctlCmdReady) state_d = WAIT;
            WAIT:    if (ctlDone)     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        ctlCmdValid = (state_q == ISSUE);
    end

    // Timer freezes while the controller is not initialised
    always_comb begin
        wrap      = ctlInitDone && (refCnt_q == REF_LAST);
        refCnt_d  = refCnt_q;
        if (ctlInitDone) refCnt_d = wrap ? '0 : refCnt_q + 1'b1;
        refPend_d = wrap || (refPend_q && !gnt_ref);
        overrun_d = overrun_q || (wrap && refPend_q && !gnt_ref);
        starve_d  = starve_q;
        if (gnt_vid) begin
            if (!drwReq)                      starve_d = '0;
            else if (starve_q != STARVE_MAX)  starve_d = starve_q + 1'b1;
        end else if (gnt_drw) begin
            starve_d = '0;
        end
    end

    always_ff @(posedge clk133_p or negedge rst_n) begin
        if (!rst_n) begin
            owner_q     <= OWN_NONE;
            cmdType_q   <= CMD_RD;
            addr_q      <= '0;
            wdata_q     <= '0;
            refCnt_q    <= '0;
            refPend_q   <= 1'b0;
            overrun_q   <= 1'b0;
            starve_q    <= '0;
            vidGrant_q  <= 1'b0;
            drwGrant_q  <= 1'b0;
            vidValid_q  <= 1'b0;
            drwDone_q   <= 1'b0;
            vidData_q   <= '0;
            drwRdData_q <= '0;
        end else begin
            refCnt_q   <= refCnt_d;
            refPend_q  <= refPend_d;
            overrun_q  <= overrun_d;
            starve_q   <= starve_d;
            vidGrant_q <= gnt_vid;
            drwGrant_q <= gnt_drw;
            if (gnt_ref) begin
                owner_q   <= OWN_REF;
                cmdType_q <= CMD_REF;
                addr_q    <= '0;
                wdata_q   <= '0;
            end else if (gnt_drw) begin
                owner_q   <= OWN_DRW;
                cmdType_q <= drwWrite ? CMD_WR : CMD_RD;
                addr_q    <= drwAddress;
                wdata_q   <= drwWriteData;
            end else if (gnt_vid) begin
                owner_q   <= OWN_VID;
                cmdType_q <= CMD_RD;
                addr_q    <= vidAddress;
                wdata_q   <= '0;
            end
            vidValid_q <= done_evt && (owner_q == OWN_VID);
            drwDone_q  <= done_evt && (owner_q == OWN_DRW);
            if (done_evt && owner_q == OWN_VID) vidData_q <= ctlReadData;
            // Writes leave the last read value on drwReadData
            if (done_evt && owner_q == OWN_DRW && cmdType_q == CMD_RD) drwRdData_q <= ctlReadData;
        end
    end

    assign vidGrant       = vidGrant_q;
    assign drwGrant       = drwGrant_q;
    assign vidDataValid   = vidValid_q;
    assign vidData        = vidData_q;
    assign drwDone        = drwDone_q;
    assign drwReadData    = drwRdData_q;
    assign ctlCmdType     = cmdType_q;
    assign ctlAddress     = addr_q;
    assign ctlWriteData   = wdata_q;
    assign refreshOverrun = overrun_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Randomised bench for ddr_arbiter: a transaction-level model predicts grants,
// commands and completions into queues; a negedge monitor pops and compares.
module tb_ddr_arbiter;

    localparam int RI = 16;
    localparam int SL = 8;

    logic        clk133_p = 1'b0, rst_n = 1'b0;
    logic        vidReq = 1'b0, drwReq = 1'b0, drwWrite = 1'b0;
    logic [23:0] vidAddress = '0, drwAddress = '0;
    logic [15:0] drwWriteData = '0, ctlReadData = '0;
    logic        ctlInitDone = 1'b0, ctlCmdReady = 1'b0, ctlDone = 1'b0;
    logic        vidGrant, vidDataValid, drwGrant, drwDone, ctlCmdValid, refreshOverrun;
    logic [15:0] vidData, drwReadData, ctlWriteData;
    logic [1:0]  ctlCmdType;
    logic [23:0] ctlAddress;

    always #5 clk133_p = ~clk133_p;

    ddr_arbiter #(.REFRESH_INTERVAL(RI), .STARVE_LIMIT(SL)) dut (
        .clk133_p(clk133_p), .rst_n(rst_n),
        .vidReq(vidReq), .vidAddress(vidAddress), .vidGrant(vidGrant),
        .vidDataValid(vidDataValid), .vidData(vidData),
        .drwReq(drwReq), .drwWrite(drwWrite), .drwAddress(drwAddress),
        .drwWriteData(drwWriteData), .drwGrant(drwGrant), .drwDone(drwDone),
        .drwReadData(drwReadData), .ctlInitDone(ctlInitDone),
        .ctlCmdValid(ctlCmdValid), .ctlCmdReady(ctlCmdReady), .ctlCmdType(ctlCmdType),
        .ctlAddress(ctlAddress), .ctlWriteData(ctlWriteData), .ctlDone(ctlDone),
        .ctlReadData(ctlReadData), .refreshOverrun(refreshOverrun)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vidGrant"},     vidGrant, 0);
        chk({tag, "_vidDataValid"}, vidDataValid, 0);
        chk({tag, "_vidData"},      vidData, 0);
        chk({tag, "_drwGrant"},     drwGrant, 0);
        chk({tag, "_drwDone"},      drwDone, 0);
        chk({tag, "_drwReadData"},  drwReadData, 0);
        chk({tag, "_ctlCmdValid"},  ctlCmdValid, 0);
        chk({tag, "_ctlCmdType"},   ctlCmdType, 0);
        chk({tag, "_ctlAddress"},   ctlAddress, 0);
        chk({tag, "_ctlWriteData"}, ctlWriteData, 0);
        chk({tag, "_overrun"},      refreshOverrun, 0);
    endtask

    // ---------------- reference model (transaction level) ----------------
    typedef struct {
        logic [1:0]  typ;
        logic [23:0] addr;
        logic [15:0] data;
    } cmd_t;

    // phase: 0 idle, 1 command offered, 2 awaiting completion; owner/winner: 1 vid, 2 drw, 3 ref
    int          m_phase, m_owner, m_cnt, m_starve, win;
    bit          m_pend, m_ovr, m_isWr, wrap;
    logic [15:0] m_lastRd;
    cmd_t        c;
    cmd_t        cq[$];
    int          gq[$];
    logic [15:0] vq[$];
    logic [15:0] dq[$];

    always @(posedge clk133_p or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_owner = 0; m_cnt = 0; m_starve = 0;
            m_pend = 0; m_ovr = 0; m_isWr = 0; m_lastRd = '0;
            cq.delete(); gq.delete(); vq.delete(); dq.delete();
        end else begin
            wrap = ctlInitDone && (m_cnt == RI - 1);
            win  = 0;
            if (m_phase == 0 && ctlInitDone) begin
                if (m_pend)                         win = 3;
                else if (drwReq && m_starve == SL)  win = 2;
                else if (vidReq)                    win = 1;
                else if (drwReq)                    win = 2;
            end
            if (wrap && m_pend && win != 3) m_ovr = 1;
            m_pend = wrap || (m_pend && win != 3);
            if (ctlInitDone) m_cnt = wrap ? 0 : m_cnt + 1;
            case (m_phase)
                0: if (win != 0) begin
                    m_phase = 1;
                    m_owner = win;
                    m_isWr  = (win == 2) && drwWrite;
                    c.typ   = (win == 3) ? 2'b10 : (m_isWr ? 2'b01 : 2'b00);
                    c.addr  = (win == 1) ? vidAddress : (win == 2) ? drwAddress : 24'h0;
                    c.data  = (win == 2) ? drwWriteData : 16'h0;
                    cq.push_back(c);
                    if (win != 3) gq.push_back(win);
                    if (win == 1)      m_starve = drwReq ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
                    else if (win == 2) m_starve = 0;
                end
                1: if (ctlCmdReady) m_phase = 2;
                2: if (ctlDone) begin
                    m_phase = 0;
                    if (m_owner == 1) vq.push_back(ctlReadData);
                    else if (m_owner == 2) begin
                        if (!m_isWr) m_lastRd = ctlReadData;
                        dq.push_back(m_lastRd);
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk133_p) begin
        if (rst_n) begin
            chk("cmd_valid", ctlCmdValid, m_phase == 1);
            chk("refresh_overrun", refreshOverrun, m_ovr);
            chk("vid_grant", vidGrant, gq.size() > 0 && gq[0] == 1);
            chk("drw_grant", drwGrant, gq.size() > 0 && gq[0] == 2);
            if (gq.size() > 0) void'(gq.pop_front());
            if (m_phase == 1 && cq.size() > 0) begin
                chk("cmd_type", ctlCmdType, cq[0].typ);
                if (cq[0].typ != 2'b10) chk("cmd_addr", ctlAddress, cq[0].addr);
                if (cq[0].typ == 2'b01) chk("cmd_wdata", ctlWriteData, cq[0].data);
                if (ctlCmdReady) void'(cq.pop_front());
            end
            chk("vid_data_valid", vidDataValid, vq.size() > 0);
            if (vq.size() > 0) begin
                if (vidDataValid) chk("vid_data", vidData, vq[0]);
                void'(vq.pop_front());
            end
            chk("drw_done", drwDone, dq.size() > 0);
            if (dq.size() > 0) begin
                if (drwDone) chk("drw_read_data", drwReadData, dq[0]);
                void'(dq.pop_front());
            end
        end
    end

    // ---------------- requesters and controller ----------------
    int vid_rate = 0, drw_rate = 0, rdy_rate = 50, done_rate = 40;
    bit hold_done = 0, stray_en = 1;

    always @(negedge clk133_p) begin
        if (!rst_n) begin
            vidReq = 0; drwReq = 0; ctlDone = 0; ctlCmdReady = 0;
        end else begin
            if (vidGrant) vidReq = 0;
            else if (!vidReq && $urandom_range(0, 99) < vid_rate) begin
                vidReq = 1; vidAddress = 24'($urandom);
            end
            if (drwGrant) drwReq = 0;
            else if (!drwReq && $urandom_range(0, 99) < drw_rate) begin
                drwReq = 1; drwWrite = 1'($urandom); drwAddress = 24'($urandom);
                drwWriteData = 16'($urandom);
            end
            ctlCmdReady = ($urandom_range(0, 99) < rdy_rate);
            if (m_phase == 2) ctlDone = !hold_done && ($urandom_range(0, 99) < done_rate);
            else              ctlDone = stray_en && ($urandom_range(0, 9) == 0);
            ctlReadData = 16'($urandom);
        end
    end

    // ---------------- sequence ----------------
    initial begin
        bit reached;
        #1 chk_all_zero("reset");
        #21 rst_n = 1;
        repeat (5) @(negedge clk133_p);
        ctlInitDone = 1;

        vid_rate = 40; drw_rate = 40;
        repeat (1500) @(negedge clk133_p);

        // Both requesters saturated with an instant controller
        vid_rate = 100; drw_rate = 100; rdy_rate = 100; done_rate = 100;
        repeat (400) @(negedge clk133_p);

        // Initialisation lost mid-traffic
        rdy_rate = 50; done_rate = 40;
        repeat (7) @(negedge clk133_p);
        ctlInitDone = 0;
        repeat (60) @(negedge clk133_p);
        ctlInitDone = 1;
        repeat (200) @(negedge clk133_p);

        // Completion withheld long enough for several refresh wraps
        rdy_rate = 100; hold_done = 1;
        repeat (60) @(negedge clk133_p);
        chk("overrun_set", refreshOverrun, 1);
        hold_done = 0;
        repeat (200) @(negedge clk133_p);
        chk("overrun_sticky", refreshOverrun, 1);

        // Asynchronous reset while a transaction is outstanding
        hold_done = 1; reached = 0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(posedge clk133_p);
            reached = (m_phase == 2);
        end
        chk("reach_wait_before_reset", reached, 1);
        #2 rst_n = 0;
        #1 chk_all_zero("async_reset");
        repeat (3) @(negedge clk133_p);
        hold_done = 0;
        rst_n = 1;

        vid_rate = 50; drw_rate = 50; rdy_rate = 60; done_rate = 50;
        repeat (800) @(negedge clk133_p);

        // Drain: no new grants, let the in-flight transaction finish
        vid_rate = 0; drw_rate = 0; rdy_rate = 100; done_rate = 100; stray_en = 0;
        ctlInitDone = 0;
        repeat (50) @(negedge clk133_p);
        @(posedge clk133_p); #1;
        chk("drain_cmd_q", cq.size(), 0);
        chk("drain_grant_q", gq.size(), 0);
        chk("drain_vid_q", vq.size(), 0);
        chk("drain_drw_q", dq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
